// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose: groups the requester-side req/done handshake signals and the
// memory-side req/ack port of the two-requester memory port arbiter.
//
// Parameters:
//   WIDTH - data bus width
//   AW    - address width
//
// Signals:
//   req0/req1, addr0/addr1, wdata0/wdata1, we0/we1 : requester transactions
//   done0/done1, rdata                             : completion back to requesters
//   mem_req, mem_addr, mem_wdata, mem_we           : shared memory port
//   mem_ack, mem_rdata                             : memory completion
//   sel                                            : mux select (1 = requester 1)
//
// Modports:
//   slave  - the arbiter side
//   master - the environment (requesters plus memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 32
);
    logic             req0;
    logic             req1;
    logic [AW-1:0]    addr0;
    logic [AW-1:0]    addr1;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic             we0;
    logic             we1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] rdata;
    logic             mem_req;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
    logic             sel;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
        input  mem_ack, mem_rdata,
        output done0, done1, rdata,
        output mem_req, mem_addr, mem_wdata, mem_we, sel
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
        output mem_ack, mem_rdata,
        input  done0, done1, rdata,
        input  mem_req, mem_addr, mem_wdata, mem_we, sel
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: shares one memory port between instruction fetch (requester 0) and
// data access (requester 1). A grant is held until memory acknowledges; on the
// ack the arbiter hands straight over to the other requester if it is waiting,
// otherwise it returns to IDLE. Ties in IDLE are broken round-robin.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mem_port_arbiter_if.slave (requester handshakes + memory port)
//
// Parameters:
//   WIDTH - data bus width
//   AW    - address width
//
// Build option:
//   ARB_FIXED_PRIO_EN - when defined, requester 1 wins every tie in IDLE.
//                       Direct hand-over after an ack is unchanged and `last`
//                       is still tracked.
//
// States:
//   state | meaning
//   ------+----------------------------------------------
//   IDLE  | no transaction; memory port shows requester 0
//   BUSY0 | requester 0 owns the port, waiting for mem_ack
//   BUSY1 | requester 1 owns the port, waiting for mem_ack
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int AW    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY0 = 2'b01,
        BUSY1 = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   last_q;
    logic   last_d;
    logic   pick1;

    logic             sel_w;
    logic [AW-1:0]    addr_mux;
    logic [WIDTH-1:0] wdata_mux;
    logic             we_mux;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;    // requester 0 wins the first tie
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Tie-break decision used only when both requests are up in IDLE.
`ifdef ARB_FIXED_PRIO_EN
    assign pick1 = 1'b1;
`else
    assign pick1 = ~last_q;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    if (pick1) begin
                        state_d = BUSY1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = BUSY0;
                        last_d  = 1'b0;
                    end
                end else if (bus.req0) begin
                    state_d = BUSY0;
                    last_d  = 1'b0;
                end else if (bus.req1) begin
                    state_d = BUSY1;
                    last_d  = 1'b1;
                end
            end
            // The completing requester's own req is deliberately not looked
            // at in its ack cycle: it re-arbitrates from IDLE if still high.
            BUSY0: begin
                if (bus.mem_ack) begin
                    if (bus.req1) begin
                        state_d = BUSY1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BUSY1: begin
                if (bus.mem_ack) begin
                    if (bus.req0) begin
                        state_d = BUSY0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Steering muxes onto the shared port; IDLE shows requester 0.
    assign sel_w     = (state_q == BUSY1);
    assign addr_mux  = sel_w ? bus.addr1  : bus.addr0;
    assign wdata_mux = sel_w ? bus.wdata1 : bus.wdata0;
    assign we_mux    = sel_w ? bus.we1    : bus.we0;

    assign bus.sel       = sel_w;
    assign bus.mem_req   = (state_q != IDLE);
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.mem_we    = we_mux;

    // Completion is the ack itself, qualified by the owner; acks in IDLE vanish.
    assign bus.done0 = bus.mem_ack & (state_q == BUSY0);
    assign bus.done1 = bus.mem_ack & (state_q == BUSY1);
    assign bus.rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int W  = 32;
    localparam int AW = 32;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.WIDTH(W), .AW(AW)) bus ();

    mem_port_arbiter #(.WIDTH(W), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          s;
        logic [AW-1:0] addr;
        logic          we;
        logic [W-1:0]  wdata;
        logic [W-1:0]  rdata;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    int ack_delay = 1;
    bit mem_en    = 1'b0;
    bit spur      = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mem_val(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], 16'hC0DE};
    endfunction

    task automatic push_exp(input logic s, input logic [AW-1:0] a, input logic we,
                            input logic [W-1:0] wd);
        exp_t e;
        e.s = s; e.addr = a; e.we = we; e.wdata = wd; e.rdata = mem_val(a);
        sb.push_back(e);
    endtask

    // Memory model: acks each transaction ack_delay cycles after it starts.
    initial begin : mem_model
        int cnt;
        cnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0BAD0BAD;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bus.mem_ack = 1'b0;
                cnt = 0;
            end else if (!mem_en) begin
                bus.mem_ack = spur;
                cnt = 0;
            end else begin
                if (bus.mem_ack) begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = 32'h0BAD0BAD;
                    cnt = 0;
                end
                if (bus.mem_req) begin
                    if (cnt == ack_delay) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = mem_val(bus.mem_addr);
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    // Scoreboard: every completion must match the next expected transaction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done0 || bus.done1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {62'd0, bus.done1, bus.done0}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_sel",   bus.sel, e.s);
                    chk("sb_done0", bus.done0, !e.s);
                    chk("sb_done1", bus.done1, e.s);
                    chk("sb_addr",  bus.mem_addr, e.addr);
                    chk("sb_we",    bus.mem_we, e.we);
                    chk("sb_wdata", bus.mem_wdata, e.wdata);
                    chk("sb_rdata", bus.rdata, e.rdata);
                end
            end
        end
    end

    task automatic wait_done(input bit who);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((who == 1'b0 && bus.done0) || (who == 1'b1 && bus.done1)) return;
        end
        chk(who ? "done1_timeout" : "done0_timeout", 64'd0, 64'd1);
    endtask

    // One requester issuing n transactions, holding req between them.
    task automatic req_seq(input bit who, input int n, input logic [AW-1:0] base,
                           input logic we, input logic [W-1:0] wbase);
        for (int i = 0; i < n; i++) begin
            if (who) begin
                bus.addr1  = base + AW'(i * 4);
                bus.wdata1 = wbase + W'(i);
                bus.we1    = we;
                bus.req1   = 1'b1;
            end else begin
                bus.addr0  = base + AW'(i * 4);
                bus.wdata0 = wbase + W'(i);
                bus.we0    = we;
                bus.req0   = 1'b1;
            end
            wait_done(who);
            @(posedge clk);
            #1;
        end
        if (who) bus.req1 = 1'b0;
        else     bus.req0 = 1'b0;
    endtask

    // Counts cycles without mem_req between the first grant and the last done.
    task automatic watch_gap(input int target, output int gaps, output int seen);
        bit started;
        started = 1'b0;
        gaps = 0;
        seen = 0;
        for (int c = 0; c < 300 && seen < target; c++) begin
            @(negedge clk);
            if (bus.mem_req) started = 1'b1;
            else if (started) gaps++;
            if (bus.done0 || bus.done1) seen++;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int gaps;
        int seen;
        int n_d0;

        rst_n      = 1'b0;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.addr0  = 32'hABC;
        bus.addr1  = 32'h777;
        bus.wdata0 = 32'h1111;
        bus.wdata1 = 32'h2222;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;

        // Reset values
        #3;
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_sel",     bus.sel, 1'b0);
        chk("rst_done0",   bus.done0, 1'b0);
        chk("rst_done1",   bus.done1, 1'b0);
        chk("rst_addr",    bus.mem_addr, 32'hABC);
        chk("rst_wdata",   bus.mem_wdata, 32'h1111);
        do_reset();

        // Single read from requester 0, acked 2 cycles after mem_req
        mem_en    = 1'b1;
        ack_delay = 2;
        bus.addr0 = 32'h100;
        bus.we0   = 1'b0;
        bus.req0  = 1'b1;
        push_exp(1'b0, 32'h100, 1'b0, bus.wdata0);
        @(negedge clk);
        chk("rd_req_not_yet", bus.mem_req, 1'b0);
        @(posedge clk);
        #1;
        chk("rd_mem_req", bus.mem_req, 1'b1);
        chk("rd_sel",     bus.sel, 1'b0);
        chk("rd_addr",    bus.mem_addr, 32'h100);
        @(negedge clk);
        chk("rd_no_early_done", bus.done0, 1'b0);
        wait_done(1'b0);
        @(posedge clk);
        #1;
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("rd_done_1cyc", bus.done0, 1'b0);
        chk("rd_idle",      bus.mem_req, 1'b0);

        // Simultaneous requests out of reset
        do_reset();
        ack_delay = 1;
`ifdef ARB_FIXED_PRIO_EN
        push_exp(1'b1, 32'h600, 1'b0, 32'h60);
        push_exp(1'b0, 32'h610, 1'b0, 32'h61);
`else
        push_exp(1'b0, 32'h610, 1'b0, 32'h61);
        push_exp(1'b1, 32'h600, 1'b0, 32'h60);
`endif
        fork
            req_seq(1'b0, 1, 32'h610, 1'b0, 32'h61);
            req_seq(1'b1, 1, 32'h600, 1'b0, 32'h60);
            watch_gap(2, gaps, seen);
        join
        chk("sim_gaps", gaps, 0);
        chk("sim_seen", seen, 2);

        // Both hold req through 4 transactions, ack after 1 cycle
        do_reset();
`ifdef ARB_FIXED_PRIO_EN
        push_exp(1'b1, 32'h500, 1'b0, 32'h50);
        push_exp(1'b0, 32'h400, 1'b0, 32'h40);
        push_exp(1'b1, 32'h504, 1'b0, 32'h51);
        push_exp(1'b0, 32'h404, 1'b0, 32'h41);
`else
        push_exp(1'b0, 32'h400, 1'b0, 32'h40);
        push_exp(1'b1, 32'h500, 1'b0, 32'h50);
        push_exp(1'b0, 32'h404, 1'b0, 32'h41);
        push_exp(1'b1, 32'h504, 1'b0, 32'h51);
`endif
        fork
            req_seq(1'b0, 2, 32'h400, 1'b0, 32'h40);
            req_seq(1'b1, 2, 32'h500, 1'b0, 32'h50);
            watch_gap(4, gaps, seen);
        join
        chk("rr_gaps", gaps, 0);
        chk("rr_seen", seen, 4);

        // Same requester twice: second transaction re-arbitrates from IDLE
        @(posedge clk);
        #1;
        push_exp(1'b1, 32'h700, 1'b0, 32'h70);
        push_exp(1'b1, 32'h704, 1'b0, 32'h71);
        fork
            req_seq(1'b1, 2, 32'h700, 1'b0, 32'h70);
            watch_gap(2, gaps, seen);
        join
        chk("same_gaps", gaps, 1);

        // Write steered from requester 1
        @(posedge clk);
        #1;
        bus.addr1  = 32'h200;
        bus.wdata1 = 32'h55AA;
        bus.we1    = 1'b1;
        bus.req1   = 1'b1;
        push_exp(1'b1, 32'h200, 1'b1, 32'h55AA);
        @(posedge clk);
        #1;
        chk("wr_mem_req", bus.mem_req, 1'b1);
        chk("wr_sel",     bus.sel, 1'b1);
        chk("wr_we",      bus.mem_we, 1'b1);
        chk("wr_addr",    bus.mem_addr, 32'h200);
        chk("wr_wdata",   bus.mem_wdata, 32'h55AA);
        wait_done(1'b1);
        @(posedge clk);
        #1;
        bus.req1 = 1'b0;
        bus.we1  = 1'b0;
        repeat (2) @(posedge clk);

        // Spurious ack in IDLE
        mem_en = 1'b0;
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_done0",   bus.done0, 1'b0);
        chk("spur_done1",   bus.done1, 1'b0);
        chk("spur_mem_req", bus.mem_req, 1'b0);
        @(posedge clk);
        #2;
        chk("spur_state_req", bus.mem_req, 1'b0);
        chk("spur_state_sel", bus.sel, 1'b0);

        // Reset during BUSY0 before ack
        bus.addr0 = 32'h300;
        bus.req0  = 1'b1;
        @(posedge clk);
        #1;
        chk("ab0_busy", bus.mem_req, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab0_mem_req", bus.mem_req, 1'b0);
        chk("ab0_sel",     bus.sel, 1'b0);
        bus.req0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mem_en = 1'b1;
        n_d0 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done0) n_d0++;
        end
        chk("ab0_no_done0", n_d0, 0);

        // Reset during BUSY1: sel must fall without a clock edge
        mem_en    = 1'b0;
        bus.addr1 = 32'h310;
        bus.req1  = 1'b1;
        @(posedge clk);
        #1;
        chk("ab1_sel_hi", bus.sel, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab1_mem_req", bus.mem_req, 1'b0);
        chk("ab1_sel",     bus.sel, 1'b0);
        bus.req1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
